instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: receives a serial program image and writes it into instruction
// memory while holding the CPU in reset.
// Byte stream: word count N (0 means 256), then N words sent high byte first.
// Optional feature macro INSTR_LOADER_CHECKSUM_EN: after the words, one more
// byte must equal the XOR of all word bytes. A match ends in DONE, anything
// else ends in ERR.
module instr_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        IM_Wr,
  output logic [7:0]  IM_Addr,
  output logic [15:0] IM_Data,
  output logic        CPU_Reset,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  // The count is 9 bits wide because a count byte of 0 stands for 256 words.
  logic [8:0]  cnt_q, cnt_d;
  logic        accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Status outputs decode directly from the current state.
  assign Byte_Ready = (state_q == S_LEN) || (state_q == S_HI) ||
                      (state_q == S_LO)  || (state_q == S_CSUM);
  assign accept     = Byte_Valid & Byte_Ready;
  assign IM_Wr      = (state_q == S_WRITE);
  assign IM_Addr    = addr_q;
  assign IM_Data    = data_q;
  assign CPU_Reset  = (state_q != S_DONE);
  assign Done       = (state_q == S_DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign Error      = (state_q == S_ERR);
`else
  assign Error      = 1'b0;
`endif
  assign State      = state_q;

  // Next-state logic, plus updates to the address, data, count and checksum.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_LEN;
          addr_d  = BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          cnt_d   = (Byte_In == 8'h00) ? 9'd256 : {1'b0, Byte_In};
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          data_d[15:8] = Byte_In;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ Byte_In;
`endif
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          data_d[7:0] = Byte_In;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ Byte_In;
`endif
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        // Memory samples IM_Addr/IM_Data during this cycle; advance afterwards.
        addr_d = addr_q + 8'd1;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q > 9'd1) begin
          state_d = S_HI;
        end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (Byte_In == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      data_q  <= 16'h0000;
      cnt_q   <= 9'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
